// File: rtl/esfa_cell_sequencer_pkg.sv
// Shared definitions for the ESFA cell sequencer: op codes, cell selector
// codes, response status codes and the sequencer state encoding.
package esfa_cell_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_LOOKUP       = 3'd0,
    OP_INSERT       = 3'd1,
    OP_ENCODE       = 3'd2,
    OP_CONGRUE_UP   = 3'd3,
    OP_CONGRUE_DOWN = 3'd4,
    OP_ENRANK       = 3'd5,
    OP_ENRANGE      = 3'd6,
    OP_ILLEGAL      = 3'd7
  } esfaOp_t;

  localparam logic [7:0] SEL_UPDATE       = 8'd0;
  localparam logic [7:0] SEL_LOOKUP       = 8'd1;
  localparam logic [7:0] SEL_ENCODE       = 8'd2;
  localparam logic [7:0] SEL_CONGRUE_UP   = 8'd3;
  localparam logic [7:0] SEL_CONGRUE_DOWN = 8'd4;
  localparam logic [7:0] SEL_FREE         = 8'd5;
  localparam logic [7:0] SEL_ENRANK       = 8'd6;
  localparam logic [7:0] SEL_ENRANGE      = 8'd7;
  localparam logic [7:0] SEL_NOP          = 8'hFF;

  typedef enum logic [1:0] {
    STATUS_OK     = 2'd0,
    STATUS_FULL   = 2'd1,
    STATUS_BAD_OP = 2'd2
  } esfaStatus_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_WRITE,
    S_WCAPTURE,
    S_RESP
  } seqState_t;

  // First-phase cell selector for each op; INSERT starts with the free-cell scan.
  function automatic logic [7:0] opSelector(input esfaOp_t op);
    case (op)
      OP_LOOKUP:       return SEL_LOOKUP;
      OP_INSERT:       return SEL_FREE;
      OP_ENCODE:       return SEL_ENCODE;
      OP_CONGRUE_UP:   return SEL_CONGRUE_UP;
      OP_CONGRUE_DOWN: return SEL_CONGRUE_DOWN;
      OP_ENRANK:       return SEL_ENRANK;
      OP_ENRANGE:      return SEL_ENRANGE;
      default:         return SEL_NOP;
    endcase
  endfunction

endpackage

// File: rtl/esfa_prio_enc.sv
// Lowest-index priority encoder: reports the first set request bit and
// whether any bit is set at all.
module esfa_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    // NOTE: both outputs get a default before the loop so no path leaves them unassigned (no latch).
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/esfa_cell_sequencer.sv
// Command sequencer for the ESFA cell array. Takes one host op at a time,
// broadcasts selector and operands to every cell, gates per-cell write
// enables, picks the lowest responding cell and returns a single response.
module esfa_cell_sequencer
  import esfa_cell_sequencer_pkg::*;
#(
  parameter  int NUM_CELLS = 8,
  parameter  int DATA_W    = 8,
  localparam int IDX_W     = $clog2(NUM_CELLS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_op,
  input  logic [DATA_W-1:0]           cmd_handle,
  input  logic [DATA_W-1:0]           cmd_index,
  input  logic [DATA_W-1:0]           cmd_value,
  input  logic [DATA_W-1:0]           cmd_metadata,
  input  logic                        cmd_is_meta,
  output logic [7:0]                  cell_selector,
  output logic [DATA_W-1:0]           cell_handle,
  output logic [DATA_W-1:0]           cell_index,
  output logic [DATA_W-1:0]           cell_value,
  output logic [DATA_W-1:0]           cell_metadata,
  output logic                        cell_is_meta,
  output logic [NUM_CELLS-1:0]        cell_we,
  input  logic [NUM_CELLS-1:0]        cell_bool,
  input  logic [NUM_CELLS*DATA_W-1:0] cell_result,
  input  logic [NUM_CELLS*DATA_W-1:0] cell_context,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_found,
  output logic [IDX_W-1:0]            rsp_index,
  output logic [DATA_W-1:0]           rsp_value,
  output logic [DATA_W-1:0]           rsp_context,
  output logic [1:0]                  rsp_status
);

  seqState_t        state;
  esfaOp_t          opReg;
  logic [IDX_W-1:0] chosenIdx;

  logic [IDX_W-1:0]  encIdx;
  logic              encAny;
  logic [IDX_W-1:0]  lookIdx;
  logic [DATA_W-1:0] selResult;
  logic [DATA_W-1:0] selContext;

  esfa_prio_enc #(
    .N     (NUM_CELLS),
    .IDX_W (IDX_W)
  ) uPrioEnc (
    .req (cell_bool),
    .idx (encIdx),
    .any (encAny)
  );

  // The write-back capture reads the cell chosen earlier, not a fresh encode.
  assign lookIdx = (state == S_WCAPTURE) ? chosenIdx : encIdx;

  // Pick the result/context slice of the cell being reported.
  always_comb begin
    selResult  = '0;
    selContext = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (lookIdx == IDX_W'(i)) begin
        selResult  = cell_result[i*DATA_W +: DATA_W];
        selContext = cell_context[i*DATA_W +: DATA_W];
      end
    end
  end

  // Sequencer FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      opReg         <= OP_LOOKUP;
      chosenIdx     <= '0;
      cmd_ready     <= 1'b1;
      cell_selector <= SEL_NOP;
      cell_we       <= '0;
      cell_handle   <= '0;
      cell_index    <= '0;
      cell_value    <= '0;
      cell_metadata <= '0;
      cell_is_meta  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_found     <= 1'b0;
      rsp_index     <= '0;
      rsp_value     <= '0;
      rsp_context   <= '0;
      rsp_status    <= STATUS_OK;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            opReg     <= esfaOp_t'(cmd_op);
            if (esfaOp_t'(cmd_op) == OP_ILLEGAL) begin
              // Illegal op never touches the cell bus.
              state       <= S_RESP;
              rsp_valid   <= 1'b1;
              rsp_found   <= 1'b0;
              rsp_index   <= '0;
              rsp_value   <= '0;
              rsp_context <= '0;
              rsp_status  <= STATUS_BAD_OP;
            end else begin
              state         <= S_ISSUE;
              cell_handle   <= cmd_handle;
              cell_index    <= cmd_index;
              cell_value    <= cmd_value;
              cell_metadata <= cmd_metadata;
              cell_is_meta  <= cmd_is_meta;
              cell_selector <= opSelector(esfaOp_t'(cmd_op));
              if (esfaOp_t'(cmd_op) == OP_CONGRUE_UP || esfaOp_t'(cmd_op) == OP_CONGRUE_DOWN)
                cell_we <= '1;
              else
                cell_we <= '0;
            end
          end
        end

        S_ISSUE: begin
          cell_selector <= SEL_NOP;
          cell_we       <= '0;
          state         <= S_CAPTURE;
        end

        S_CAPTURE: begin
          if (opReg == OP_INSERT) begin
            if (encAny) begin
              // Write the lowest free cell in a second bus phase.
              state         <= S_WRITE;
              chosenIdx     <= encIdx;
              cell_selector <= SEL_UPDATE;
              cell_we       <= {{(NUM_CELLS-1){1'b0}}, 1'b1} << encIdx;
            end else begin
              state       <= S_RESP;
              rsp_valid   <= 1'b1;
              rsp_found   <= 1'b0;
              rsp_index   <= '0;
              rsp_value   <= '0;
              rsp_context <= '0;
              rsp_status  <= STATUS_FULL;
            end
          end else begin
            state       <= S_RESP;
            rsp_valid   <= 1'b1;
            rsp_found   <= encAny;
            rsp_index   <= encIdx;
            rsp_value   <= encAny ? selResult : '0;
            rsp_context <= encAny ? selContext : '0;
            rsp_status  <= STATUS_OK;
          end
        end

        S_WRITE: begin
          cell_selector <= SEL_NOP;
          cell_we       <= '0;
          state         <= S_WCAPTURE;
        end

        S_WCAPTURE: begin
          state       <= S_RESP;
          rsp_valid   <= 1'b1;
          rsp_found   <= cell_bool[chosenIdx];
          rsp_index   <= chosenIdx;
          rsp_value   <= selResult;
          rsp_context <= selContext;
          rsp_status  <= STATUS_OK;
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esfa_cell_sequencer.sv
// Self-checking bench for esfa_cell_sequencer. A small cell-array model
// answers each non-idle selector with a pre-planned response set; the
// expected per-cycle bus trace and response are derived from the op rules.
module tb_esfa_cell_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_handle, cmd_index, cmd_value, cmd_metadata;
  logic        cmd_is_meta;
  logic [7:0]  cell_selector;
  logic [7:0]  cell_handle, cell_index, cell_value, cell_metadata;
  logic        cell_is_meta;
  logic [7:0]  cell_we;
  logic [7:0]  cell_bool;
  logic [63:0] cell_result, cell_context;
  logic        rsp_valid, rsp_ready, rsp_found;
  logic [2:0]  rsp_index;
  logic [7:0]  rsp_value, rsp_context;
  logic [1:0]  rsp_status;

  int total = 0;
  int bad   = 0;

  // Planned cell responses: set 0 answers the first bus phase, set 1 the second.
  logic [7:0]  rBool [2];
  logic [63:0] rRes  [2];
  logic [63:0] rCtx  [2];
  int          respPhase = 2;
  logic [7:0]  selSeen;

  logic [7:0] selTab [0:7] = '{8'd1, 8'd5, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'hFF};

  esfa_cell_sequencer #(.NUM_CELLS(8), .DATA_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_handle    (cmd_handle),
    .cmd_index     (cmd_index),
    .cmd_value     (cmd_value),
    .cmd_metadata  (cmd_metadata),
    .cmd_is_meta   (cmd_is_meta),
    .cell_selector (cell_selector),
    .cell_handle   (cell_handle),
    .cell_index    (cell_index),
    .cell_value    (cell_value),
    .cell_metadata (cell_metadata),
    .cell_is_meta  (cell_is_meta),
    .cell_we       (cell_we),
    .cell_bool     (cell_bool),
    .cell_result   (cell_result),
    .cell_context  (cell_context),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_found     (rsp_found),
    .rsp_index     (rsp_index),
    .rsp_value     (rsp_value),
    .rsp_context   (rsp_context),
    .rsp_status    (rsp_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lowestSet(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Cell array: registered outputs, so a selector seen in one cycle yields
  // a valid answer in the next. Idle cycles return noise.
  initial begin
    cell_bool    = '0;
    cell_result  = '0;
    cell_context = '0;
    forever begin
      @(negedge clk);
      selSeen = cell_selector;
      @(posedge clk);
      #1;
      if (selSeen != 8'hFF && respPhase < 2) begin
        cell_bool    = rBool[respPhase];
        cell_result  = rRes[respPhase];
        cell_context = rCtx[respPhase];
        respPhase++;
      end else begin
        cell_bool    = 8'($urandom);
        cell_result  = {$urandom, $urandom};
        cell_context = {$urandom, $urandom};
      end
    end
  end

  task automatic junkCmd();
    cmd_op       = 3'($urandom);
    cmd_handle   = 8'($urandom);
    cmd_index    = 8'($urandom);
    cmd_value    = 8'($urandom);
    cmd_metadata = 8'($urandom);
    cmd_is_meta  = 1'($urandom);
  endtask

  // One complete transaction: issue, follow the bus cycle by cycle, check
  // the response, hold rsp_ready low for holdCycles, then hand-shake.
  task automatic doOp(input logic [2:0] op, input int holdCycles,
                      output logic gotFound, output logic [2:0] gotIdx,
                      output logic [7:0] gotVal, output logic [7:0] gotCtx,
                      output logic [1:0] gotStat);
    logic [7:0] h, ix, v, m;
    logic       im;
    logic [7:0] expSel [6];
    logic [7:0] expWe  [6];
    int         lat, low;
    logic       expFound;
    logic [2:0] expIdx;
    logic [7:0] expVal, expCtx;
    logic [1:0] expStat;

    h = 8'($urandom); ix = 8'($urandom); v = 8'($urandom); m = 8'($urandom);
    im = 1'($urandom);

    // Reference: what the bus and response must look like for this op.
    for (int i = 0; i < 6; i++) begin
      expSel[i] = 8'hFF;
      expWe[i]  = 8'h00;
    end
    low      = lowestSet(rBool[0]);
    expFound = 1'b0; expIdx = 3'd0; expVal = 8'd0; expCtx = 8'd0; expStat = 2'd0;
    if (op == 3'd7) begin
      lat     = 1;
      expStat = 2'd2;
    end else if (op == 3'd1) begin
      expSel[1] = 8'd5;
      if (low < 0) begin
        lat     = 3;
        expStat = 2'd1;
      end else begin
        lat       = 5;
        expSel[3] = 8'd0;
        expWe[3]  = 8'h01 << low;
        expIdx    = 3'(low);
        expFound  = rBool[1][low];
        expVal    = rRes[1][low*8 +: 8];
        expCtx    = rCtx[1][low*8 +: 8];
      end
    end else begin
      lat       = 3;
      expSel[1] = selTab[op];
      expWe[1]  = (op == 3'd3 || op == 3'd4) ? 8'hFF : 8'h00;
      if (low >= 0) begin
        expFound = 1'b1;
        expIdx   = 3'(low);
        expVal   = rRes[0][low*8 +: 8];
        expCtx   = rCtx[0][low*8 +: 8];
      end
    end

    @(negedge clk);
    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_op = op; cmd_handle = h; cmd_index = ix;
    cmd_value = v; cmd_metadata = m; cmd_is_meta = im;
    respPhase = 0;

    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_valid = 1'b0;
        junkCmd();
        if (op != 3'd7) begin
          check("op_handle", 64'(cell_handle), 64'(h));
          check("op_index", 64'(cell_index), 64'(ix));
          check("op_value", 64'(cell_value), 64'(v));
          check("op_meta", 64'(cell_metadata), 64'(m));
          check("op_is_meta", 64'(cell_is_meta), 64'(im));
        end
      end
      if (c < lat) begin
        check("rsp_valid_early", 64'(rsp_valid), 64'(0));
        check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
        check("selector", 64'(cell_selector), 64'(expSel[c]));
        check("cell_we", 64'(cell_we), 64'(expWe[c]));
      end
    end

    check("rsp_valid_latency", 64'(rsp_valid), 64'(1));
    check("rsp_sel_nop", 64'(cell_selector), 64'hFF);
    check("rsp_we_zero", 64'(cell_we), 64'(0));
    check("rsp_found", 64'(rsp_found), 64'(expFound));
    check("rsp_index", 64'(rsp_index), 64'(expIdx));
    check("rsp_value", 64'(rsp_value), 64'(expVal));
    check("rsp_context", 64'(rsp_context), 64'(expCtx));
    check("rsp_status", 64'(rsp_status), 64'(expStat));
    gotFound = rsp_found; gotIdx = rsp_index; gotVal = rsp_value;
    gotCtx = rsp_context; gotStat = rsp_status;

    // Host stalls with a new command already offered; it must not be taken.
    cmd_valid = 1'b1;
    for (int k = 0; k < holdCycles; k++) begin
      @(negedge clk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'(1));
      check("hold_cmd_ready", 64'(cmd_ready), 64'(0));
      check("hold_value", 64'({rsp_found, rsp_index, rsp_value, rsp_context, rsp_status}),
            64'({expFound, expIdx, expVal, expCtx, expStat}));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 64'(rsp_valid), 64'(0));
    check("post_cmd_ready", 64'(cmd_ready), 64'(1));
    check("post_sel", 64'(cell_selector), 64'hFF);
  endtask

  initial begin
    logic       f;
    logic [2:0] gi;
    logic [7:0] gv, gc;
    logic [1:0] gs;

    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    junkCmd();
    rBool[0] = '0; rBool[1] = '0; rRes[0] = '0; rRes[1] = '0; rCtx[0] = '0; rCtx[1] = '0;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    check("reset_selector", 64'(cell_selector), 64'hFF);
    check("reset_we", 64'(cell_we), 64'(0));
    check("reset_operands", 64'({cell_handle, cell_index, cell_value, cell_metadata, cell_is_meta}), 64'(0));
    check("reset_rsp", 64'({rsp_valid, rsp_found, rsp_index, rsp_value, rsp_context, rsp_status}), 64'(0));
    reset = 1'b0;

    // LOOKUP, cells 2 and 5 respond: lowest (cell 2) wins.
    rBool[0] = 8'b0010_0100;
    rRes[0]  = 64'h8877_6655_4433_2211;
    rCtx[0]  = 64'hF8F7_F6F5_F4F3_F2F1;
    doOp(3'd0, 0, f, gi, gv, gc, gs);
    check("lit_lookup_idx", 64'(gi), 64'(2));
    check("lit_lookup_val", 64'(gv), 64'h33);
    check("lit_lookup_ctx", 64'(gc), 64'hF3);

    // INSERT with only cell 7 free.
    rBool[0] = 8'h80;
    rBool[1] = 8'h80;
    rRes[1]  = 64'hA7A6_A5A4_A3A2_A1A0;
    rCtx[1]  = 64'hC7C6_C5C4_C3C2_C1C0;
    doOp(3'd1, 1, f, gi, gv, gc, gs);
    check("lit_insert_idx", 64'(gi), 64'(7));
    check("lit_insert_status", 64'(gs), 64'(0));
    check("lit_insert_val", 64'(gv), 64'hA7);

    // INSERT with the array full.
    rBool[0] = 8'h00;
    doOp(3'd1, 0, f, gi, gv, gc, gs);
    check("lit_full_status", 64'(gs), 64'(1));
    check("lit_full_found", 64'(f), 64'(0));

    // CONGRUE_UP broadcast write, then illegal op, then a 4-cycle stall.
    rBool[0] = 8'h00;
    doOp(3'd3, 0, f, gi, gv, gc, gs);
    doOp(3'd7, 0, f, gi, gv, gc, gs);
    check("lit_bad_status", 64'(gs), 64'(2));
    rBool[0] = 8'h41;
    doOp(3'd2, 4, f, gi, gv, gc, gs);
    check("lit_stall_idx", 64'(gi), 64'(0));

    // Reset while the INSERT write phase is on the bus.
    rBool[0] = 8'h12;
    rBool[1] = 8'hFF;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd1; respPhase = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_write_we", 64'(cell_we), 64'h02);
    check("rst_write_sel", 64'(cell_selector), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_we", 64'(cell_we), 64'(0));
    check("rst_mid_sel", 64'(cell_selector), 64'hFF);
    check("rst_mid_ready", 64'(cmd_ready), 64'(1));
    check("rst_mid_operand", 64'(cell_handle), 64'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_no_rsp", 64'(rsp_valid), 64'(0));
      check("rst_idle_ready", 64'(cmd_ready), 64'(1));
    end

    // Randomised traffic.
    for (int n = 0; n < 80; n++) begin
      rBool[0] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rBool[1] = 8'($urandom);
      rRes[0]  = {$urandom, $urandom};
      rRes[1]  = {$urandom, $urandom};
      rCtx[0]  = {$urandom, $urandom};
      rCtx[1]  = {$urandom, $urandom};
      doOp(3'($urandom_range(0, 7)), $urandom_range(0, 3), f, gi, gv, gc, gs);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
